// File: rtl/ahb_lite_bus_arbiter_if.sv
// Signal bundle shared by the two AHB-Lite masters, the muxed slave side of
// the SoC bus and the arbiter. The arbiter connects through the slave
// modport: to each master it looks like a slave port, and it drives the
// shared bus address/data phase. The master modport is the environment's
// view: it drives both masters' requests and the muxed slave response.
interface ahb_lite_bus_arbiter_if #(
   parameter int W = 32
);
   // Master 0 (Cortex-M0, default owner) request and return path
   logic [1:0]   HTRANS_M0;
   logic [W-1:0] HADDR_M0;
   logic         HWRITE_M0;
   logic [2:0]   HSIZE_M0;
   logic [2:0]   HBURST_M0;
   logic [3:0]   HPROT_M0;
   logic         HMASTLOCK_M0;
   logic [W-1:0] HWDATA_M0;
   logic         HREADY_M0;
   logic         HRESP_M0;
   logic [W-1:0] HRDATA_M0;

   // Master 1 (DMA/MMA loader) request and return path
   logic [1:0]   HTRANS_M1;
   logic [W-1:0] HADDR_M1;
   logic         HWRITE_M1;
   logic [2:0]   HSIZE_M1;
   logic [2:0]   HBURST_M1;
   logic [3:0]   HPROT_M1;
   logic         HMASTLOCK_M1;
   logic [W-1:0] HWDATA_M1;
   logic         HREADY_M1;
   logic         HRESP_M1;
   logic [W-1:0] HRDATA_M1;

   // Muxed slave response coming back from the bus mux
   logic         HREADY;
   logic         HRESP;
   logic [W-1:0] HRDATA;

   // Shared bus address/data phase driven by the arbiter
   logic [1:0]   HTRANS;
   logic [W-1:0] HADDR;
   logic         HWRITE;
   logic [2:0]   HSIZE;
   logic [2:0]   HBURST;
   logic [3:0]   HPROT;
   logic         HMASTLOCK;
   logic [W-1:0] HWDATA;
   logic         HMASTER;
   logic         STARVE;

   modport slave (
      input  HTRANS_M0, HADDR_M0, HWRITE_M0, HSIZE_M0, HBURST_M0, HPROT_M0,
             HMASTLOCK_M0, HWDATA_M0,
      input  HTRANS_M1, HADDR_M1, HWRITE_M1, HSIZE_M1, HBURST_M1, HPROT_M1,
             HMASTLOCK_M1, HWDATA_M1,
      input  HREADY, HRESP, HRDATA,
      output HREADY_M0, HRESP_M0, HRDATA_M0,
      output HREADY_M1, HRESP_M1, HRDATA_M1,
      output HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
             HWDATA, HMASTER, STARVE
   );

   modport master (
      output HTRANS_M0, HADDR_M0, HWRITE_M0, HSIZE_M0, HBURST_M0, HPROT_M0,
             HMASTLOCK_M0, HWDATA_M0,
      output HTRANS_M1, HADDR_M1, HWRITE_M1, HSIZE_M1, HBURST_M1, HPROT_M1,
             HMASTLOCK_M1, HWDATA_M1,
      output HREADY, HRESP, HRDATA,
      input  HREADY_M0, HRESP_M0, HRDATA_M0,
      input  HREADY_M1, HRESP_M1, HRDATA_M1,
      input  HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
             HWDATA, HMASTER, STARVE
   );
endinterface

// File: rtl/ahb_lite_bus_arbiter.sv
// Two-master AHB-Lite arbiter for the shared SoC bus. M0 is the default
// owner after reset; M1 is the DMA/MMA loader. Ownership only moves at an
// accepted, unlocked IDLE address phase of the current owner, so bursts
// (including open-ended INCR) are never split. The non-owner is stalled via
// its HREADY until granted, and the time it spends waiting is counted so a
// starvation flag can be raised.
module ahb_lite_bus_arbiter #(
   parameter int W        = 32,
   parameter int MAX_WAIT = 64,
   parameter int CNT_W    = 8
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   ahb_lite_bus_arbiter_if.slave bus
);

   typedef enum logic {
      OWNER_M0 = 1'b0,
      OWNER_M1 = 1'b1
   } owner_e;

   localparam logic [1:0]       HTRANS_IDLE = 2'b00;
   localparam logic [CNT_W-1:0] WAIT_LIMIT  = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] WAIT_SAT    = {CNT_W{1'b1}};

   owner_e           grant;
   owner_e           data_owner;
   logic [CNT_W-1:0] wait_cnt;
   logic             starve_q;

   logic [1:0]       owner_htrans;
   logic             owner_lock;
   logic             req_other;
   logic             handover;

   logic [W-1:0]     haddr_mux;
   logic [W-1:0]     hwdata_mux;

   // Pick out the current owner's transfer type and lock, and whether the
   // master that does not own the bus is asking for it.
   always_comb begin
      owner_htrans = bus.HTRANS_M0;
      owner_lock   = bus.HMASTLOCK_M0;
      req_other    = bus.HTRANS_M1[1];
      if (grant == OWNER_M1) begin
         owner_htrans = bus.HTRANS_M1;
         owner_lock   = bus.HMASTLOCK_M1;
         req_other    = bus.HTRANS_M0[1];
      end
   end

   // BUSY is deliberately not a handover point: only a completed, unlocked
   // IDLE of the owner with the other master waiting moves the grant.
   assign handover = bus.HREADY && (owner_htrans == HTRANS_IDLE) &&
                     !owner_lock && req_other;

   // Arbitration state: address owner, data-phase owner, wait counter and
   // the registered starvation flag. Parking keeps the last owner.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         grant      <= OWNER_M0;
         data_owner <= OWNER_M0;
         wait_cnt   <= '0;
         starve_q   <= 1'b0;
      end else begin
         if (handover) begin
            grant <= (grant == OWNER_M0) ? OWNER_M1 : OWNER_M0;
         end

         if (bus.HREADY) begin
            data_owner <= grant;
         end

         if (handover || !req_other) begin
            wait_cnt <= '0;
         end else if (wait_cnt != WAIT_SAT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end

         starve_q <= (wait_cnt >= WAIT_LIMIT);
      end
   end

   // Address/control phase follows the registered grant.
   always_comb begin
      bus.HTRANS    = bus.HTRANS_M0;
      haddr_mux     = bus.HADDR_M0;
      bus.HWRITE    = bus.HWRITE_M0;
      bus.HSIZE     = bus.HSIZE_M0;
      bus.HBURST    = bus.HBURST_M0;
      bus.HPROT     = bus.HPROT_M0;
      bus.HMASTLOCK = bus.HMASTLOCK_M0;
      if (grant == OWNER_M1) begin
         bus.HTRANS    = bus.HTRANS_M1;
         haddr_mux     = bus.HADDR_M1;
         bus.HWRITE    = bus.HWRITE_M1;
         bus.HSIZE     = bus.HSIZE_M1;
         bus.HBURST    = bus.HBURST_M1;
         bus.HPROT     = bus.HPROT_M1;
         bus.HMASTLOCK = bus.HMASTLOCK_M1;
      end
   end

   // Write data lags the address by one accepted phase, so it follows the
   // data-phase owner rather than the grant.
   always_comb begin
      hwdata_mux = bus.HWDATA_M0;
      if (data_owner == OWNER_M1) begin
         hwdata_mux = bus.HWDATA_M1;
      end
   end

   assign bus.HADDR   = haddr_mux;
   assign bus.HWDATA  = hwdata_mux;
   assign bus.HMASTER = grant;
   assign bus.STARVE  = starve_q;

   // Only the address owner sees the bus ready; the other master is held off.
   assign bus.HREADY_M0 = (grant == OWNER_M0) && bus.HREADY;
   assign bus.HREADY_M1 = (grant == OWNER_M1) && bus.HREADY;

   // Responses belong to whichever master's data phase is on the bus.
   assign bus.HRESP_M0 = (data_owner == OWNER_M0) && bus.HRESP;
   assign bus.HRESP_M1 = (data_owner == OWNER_M1) && bus.HRESP;

   assign bus.HRDATA_M0 = bus.HRDATA;
   assign bus.HRDATA_M1 = bus.HRDATA;

endmodule

// File: tb/tb_ahb_lite_bus_arbiter.sv
// Testbench for ahb_lite_bus_arbiter. Each scenario task drives one cycle at
// a time, pushes the outputs it expects (tagged with the cycle they are due)
// onto a scoreboard queue, and pops/compares whatever is due in the current
// cycle. Expected values are derived by hand from the arbiter's behaviour.
module tb_ahb_lite_bus_arbiter;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] BUSY   = 2'b01;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;
   localparam logic [2:0] SINGLE = 3'b000;
   localparam logic [2:0] INCR4  = 3'b011;

   typedef enum int {
      S_HMASTER, S_HADDR, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT, S_HMASTLOCK,
      S_HTRANS, S_HWDATA, S_HREADY_M0, S_HREADY_M1, S_HRESP_M0, S_HRESP_M1,
      S_HRDATA_M0, S_HRDATA_M1, S_STARVE
   } sig_e;

   typedef struct {
      int          due;
      string       tag;
      sig_e        sel;
      logic [31:0] exp;
   } exp_t;

   logic HCLK;
   logic HRESET;
   int   cyc;
   int   checks;
   int   errors;
   exp_t sb[$];

   ahb_lite_bus_arbiter_if #(.W(32)) bus ();

   ahb_lite_bus_arbiter #(.W(32), .MAX_WAIT(4), .CNT_W(3)) dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   // Cycle index used to schedule scoreboard expectations
   always @(posedge HCLK) cyc <= cyc + 1;

   function automatic logic [31:0] observe(sig_e s);
      case (s)
         S_HMASTER:   return {31'd0, bus.HMASTER};
         S_HADDR:     return bus.HADDR;
         S_HWRITE:    return {31'd0, bus.HWRITE};
         S_HSIZE:     return {29'd0, bus.HSIZE};
         S_HBURST:    return {29'd0, bus.HBURST};
         S_HPROT:     return {28'd0, bus.HPROT};
         S_HMASTLOCK: return {31'd0, bus.HMASTLOCK};
         S_HTRANS:    return {30'd0, bus.HTRANS};
         S_HWDATA:    return bus.HWDATA;
         S_HREADY_M0: return {31'd0, bus.HREADY_M0};
         S_HREADY_M1: return {31'd0, bus.HREADY_M1};
         S_HRESP_M0:  return {31'd0, bus.HRESP_M0};
         S_HRESP_M1:  return {31'd0, bus.HRESP_M1};
         S_HRDATA_M0: return bus.HRDATA_M0;
         S_HRDATA_M1: return bus.HRDATA_M1;
         S_STARVE:    return {31'd0, bus.STARVE};
         default:     return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic push(input int dly, input string tag, input sig_e s, input logic [31:0] v);
      sb.push_back('{due: cyc + dly, tag: tag, sel: s, exp: v});
   endtask

   task automatic drive_m0(input logic [1:0] t, input logic [31:0] a, input logic w,
                           input logic [2:0] b, input logic l);
      bus.HTRANS_M0    = t;
      bus.HADDR_M0     = a;
      bus.HWRITE_M0    = w;
      bus.HBURST_M0    = b;
      bus.HMASTLOCK_M0 = l;
      bus.HSIZE_M0     = 3'b010;
      bus.HPROT_M0     = 4'b0011;
   endtask

   task automatic drive_m1(input logic [1:0] t, input logic [31:0] a, input logic w,
                           input logic [2:0] b, input logic l);
      bus.HTRANS_M1    = t;
      bus.HADDR_M1     = a;
      bus.HWRITE_M1    = w;
      bus.HBURST_M1    = b;
      bus.HMASTLOCK_M1 = l;
      bus.HSIZE_M1     = 3'b001;
      bus.HPROT_M1     = 4'b0001;
   endtask

   task automatic idle_all();
      drive_m0(IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
      drive_m1(IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
      bus.HWDATA_M0 = 32'h0;
      bus.HWDATA_M1 = 32'h0;
      bus.HREADY    = 1'b1;
      bus.HRESP     = 1'b0;
      bus.HRDATA    = 32'h0;
   endtask

   task automatic do_reset();
      HRESET = 1'b1;
      idle_all();
      @(posedge HCLK);
      #1;
      HRESET = 1'b0;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         if (c < 2) begin
            HRESET = 1'b1;
            drive_m0(NONSEQ, 32'h1000_0000, 1'b0, SINGLE, 1'b0);
            drive_m1(NONSEQ, 32'h2000_0000, 1'b1, SINGLE, 1'b0);
            bus.HRDATA = 32'hDEAD_BEEF;
            push(0, "rst_hmaster", S_HMASTER, 32'd0);
            push(0, "rst_hready_m1", S_HREADY_M1, 32'd0);
            push(0, "rst_hready_m0", S_HREADY_M0, 32'd1);
            push(0, "rst_haddr", S_HADDR, 32'h1000_0000);
            push(0, "rst_starve", S_STARVE, 32'd0);
            push(0, "hrdata_m0", S_HRDATA_M0, 32'hDEAD_BEEF);
            push(0, "hrdata_m1", S_HRDATA_M1, 32'hDEAD_BEEF);
         end else begin
            HRESET = 1'b0;
            idle_all();
            push(0, "rst_release_htrans", S_HTRANS, 32'd0);
         end
         #2;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
               checks++;
               if (observe(sb[i].sel) !== sb[i].exp) begin
                  errors++;
                  $display("[TB] FAIL %s cyc %0d: got %h expected %h", sb[i].tag, cyc, observe(sb[i].sel), sb[i].exp);
               end
               sb.delete(i);
            end
         end
         @(posedge HCLK);
         #1;
      end
   endtask

   task automatic test_handover();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         case (c)
            0: begin
               drive_m0(IDLE, 32'h1000_0000, 1'b0, SINGLE, 1'b0);
               drive_m1(NONSEQ, 32'h2000_0000, 1'b1, SINGLE, 1'b0);
               bus.HWDATA_M0 = 32'h1111_1111;
               bus.HWDATA_M1 = 32'h0;
               push(0, "ho_hmaster_before", S_HMASTER, 32'd0);
               push(0, "ho_hready_m1_stall", S_HREADY_M1, 32'd0);
               push(1, "ho_hmaster", S_HMASTER, 32'd1);
               push(1, "ho_haddr", S_HADDR, 32'h2000_0000);
               push(1, "ho_hwrite", S_HWRITE, 32'd1);
               push(1, "ho_hsize", S_HSIZE, 32'd1);
               push(1, "ho_hprot", S_HPROT, 32'd1);
               push(1, "ho_hready_m1", S_HREADY_M1, 32'd1);
               push(1, "ho_hready_m0", S_HREADY_M0, 32'd0);
               push(1, "ho_hwdata_lag", S_HWDATA, 32'h1111_1111);
               push(2, "ho_hwdata", S_HWDATA, 32'hA5A5_A5A5);
               push(2, "ho_hready_m0_data", S_HREADY_M0, 32'd0);
               push(3, "park_hmaster", S_HMASTER, 32'd1);
            end
            2: begin
               drive_m1(IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
               bus.HWDATA_M1 = 32'hA5A5_A5A5;
            end
            default: ;
         endcase
         #2;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
               checks++;
               if (observe(sb[i].sel) !== sb[i].exp) begin
                  errors++;
                  $display("[TB] FAIL %s cyc %0d: got %h expected %h", sb[i].tag, cyc, observe(sb[i].sel), sb[i].exp);
               end
               sb.delete(i);
            end
         end
         @(posedge HCLK);
         #1;
      end
   endtask

   task automatic test_burst();
      do_reset();
      for (int c = 0; c < 8; c++) begin
         case (c)
            0: begin
               drive_m0(NONSEQ, 32'h0000_0100, 1'b0, INCR4, 1'b0);
               push(0, "burst_hburst", S_HBURST, 32'd3);
               push(0, "burst_b0_hmaster", S_HMASTER, 32'd0);
            end
            1: begin
               drive_m0(SEQ, 32'h0000_0104, 1'b0, INCR4, 1'b0);
               drive_m1(NONSEQ, 32'h2000_0040, 1'b0, SINGLE, 1'b0);
               bus.HREADY = 1'b0;
               push(0, "burst_wait_hready_m0", S_HREADY_M0, 32'd0);
               push(0, "burst_wait_hready_m1", S_HREADY_M1, 32'd0);
               push(0, "burst_b1_hmaster", S_HMASTER, 32'd0);
            end
            2: begin
               bus.HREADY = 1'b1;
               push(0, "burst_b1_hmaster_held", S_HMASTER, 32'd0);
               push(0, "burst_b1_haddr", S_HADDR, 32'h0000_0104);
            end
            3: begin
               drive_m0(SEQ, 32'h0000_0108, 1'b0, INCR4, 1'b0);
               push(0, "burst_b2_hmaster", S_HMASTER, 32'd0);
            end
            4: begin
               drive_m0(BUSY, 32'h0000_010C, 1'b0, INCR4, 1'b0);
               push(0, "burst_busy_htrans", S_HTRANS, 32'd1);
               push(0, "burst_busy_hmaster", S_HMASTER, 32'd0);
            end
            5: begin
               drive_m0(SEQ, 32'h0000_010C, 1'b0, INCR4, 1'b0);
               push(0, "burst_b3_hmaster", S_HMASTER, 32'd0);
               push(0, "burst_b3_hready_m1", S_HREADY_M1, 32'd0);
            end
            6: begin
               drive_m0(IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
               push(0, "burst_idle_hmaster", S_HMASTER, 32'd0);
               push(1, "burst_after_hmaster", S_HMASTER, 32'd1);
               push(1, "burst_after_haddr", S_HADDR, 32'h2000_0040);
               push(1, "burst_after_hready_m1", S_HREADY_M1, 32'd1);
            end
            default: ;
         endcase
         #2;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
               checks++;
               if (observe(sb[i].sel) !== sb[i].exp) begin
                  errors++;
                  $display("[TB] FAIL %s cyc %0d: got %h expected %h", sb[i].tag, cyc, observe(sb[i].sel), sb[i].exp);
               end
               sb.delete(i);
            end
         end
         @(posedge HCLK);
         #1;
      end
   endtask

   task automatic test_lock();
      do_reset();
      for (int c = 0; c < 6; c++) begin
         case (c)
            0: begin
               drive_m0(NONSEQ, 32'h0000_0300, 1'b0, SINGLE, 1'b1);
               drive_m1(NONSEQ, 32'h2000_0080, 1'b0, SINGLE, 1'b0);
               push(0, "lock_hmastlock", S_HMASTLOCK, 32'd1);
            end
            1: begin
               drive_m0(IDLE, 32'h0, 1'b0, SINGLE, 1'b1);
               push(0, "lock_idle_hmaster", S_HMASTER, 32'd0);
               push(1, "lock_no_handover", S_HMASTER, 32'd0);
            end
            2: begin
               drive_m0(NONSEQ, 32'h0000_0304, 1'b0, SINGLE, 1'b1);
               push(1, "lock_still_m0", S_HMASTER, 32'd0);
            end
            3: begin
               drive_m0(IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
               bus.HREADY = 1'b0;
               push(0, "unlock_hmastlock", S_HMASTLOCK, 32'd0);
               push(1, "idle_wait_no_handover", S_HMASTER, 32'd0);
            end
            4: begin
               bus.HREADY = 1'b1;
               push(0, "unlock_hready_m0", S_HREADY_M0, 32'd1);
               push(0, "lock_count_starve_low", S_STARVE, 32'd0);
               push(1, "unlock_handover", S_HMASTER, 32'd1);
               push(1, "lock_count_starve_high", S_STARVE, 32'd1);
            end
            5: begin
               push(0, "unlock_haddr", S_HADDR, 32'h2000_0080);
            end
            default: ;
         endcase
         #2;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
               checks++;
               if (observe(sb[i].sel) !== sb[i].exp) begin
                  errors++;
                  $display("[TB] FAIL %s cyc %0d: got %h expected %h", sb[i].tag, cyc, observe(sb[i].sel), sb[i].exp);
               end
               sb.delete(i);
            end
         end
         @(posedge HCLK);
         #1;
      end
   endtask

   task automatic test_starve();
      do_reset();
      for (int c = 0; c < 14; c++) begin
         if (c <= 10) begin
            drive_m0(NONSEQ, 32'h0000_0400 + 32'(4 * c), 1'b0, SINGLE, 1'b0);
         end else begin
            drive_m0(IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
         end
         if (c <= 12) begin
            drive_m1(NONSEQ, 32'h2000_00C0, 1'b0, SINGLE, 1'b0);
         end else begin
            drive_m1(IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
         end
         if (c == 0) begin
            push(3, "starve_low_c3", S_STARVE, 32'd0);
            push(4, "starve_low_c4", S_STARVE, 32'd0);
            push(5, "starve_set", S_STARVE, 32'd1);
            push(9, "starve_sat_c9", S_STARVE, 32'd1);
            push(10, "starve_sat_c10", S_STARVE, 32'd1);
            push(11, "starve_idle_hmaster", S_HMASTER, 32'd0);
            push(12, "starve_handover", S_HMASTER, 32'd1);
            push(12, "starve_hold", S_STARVE, 32'd1);
            push(13, "starve_clear", S_STARVE, 32'd0);
         end
         #2;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
               checks++;
               if (observe(sb[i].sel) !== sb[i].exp) begin
                  errors++;
                  $display("[TB] FAIL %s cyc %0d: got %h expected %h", sb[i].tag, cyc, observe(sb[i].sel), sb[i].exp);
               end
               sb.delete(i);
            end
         end
         @(posedge HCLK);
         #1;
      end
   endtask

   task automatic test_resp();
      do_reset();
      for (int c = 0; c < 6; c++) begin
         case (c)
            0: begin
               drive_m0(IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
               drive_m1(NONSEQ, 32'h2000_0100, 1'b0, SINGLE, 1'b0);
               push(1, "resp_grant_m1", S_HMASTER, 32'd1);
            end
            2: begin
               drive_m1(IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
               drive_m0(NONSEQ, 32'h0000_0500, 1'b0, SINGLE, 1'b0);
               push(0, "resp_okay_m1", S_HRESP_M1, 32'd0);
               push(1, "resp_grant_back", S_HMASTER, 32'd0);
            end
            3: begin
               bus.HREADY = 1'b0;
               bus.HRESP  = 1'b1;
               push(0, "resp_err1_m1", S_HRESP_M1, 32'd1);
               push(0, "resp_err1_m0", S_HRESP_M0, 32'd0);
               push(0, "resp_err1_hready_m0", S_HREADY_M0, 32'd0);
            end
            4: begin
               bus.HREADY = 1'b1;
               push(0, "resp_err2_m1", S_HRESP_M1, 32'd1);
               push(0, "resp_err2_m0", S_HRESP_M0, 32'd0);
            end
            5: begin
               push(0, "resp_m0_route", S_HRESP_M0, 32'd1);
               push(0, "resp_m1_masked", S_HRESP_M1, 32'd0);
            end
            default: ;
         endcase
         #2;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
               checks++;
               if (observe(sb[i].sel) !== sb[i].exp) begin
                  errors++;
                  $display("[TB] FAIL %s cyc %0d: got %h expected %h", sb[i].tag, cyc, observe(sb[i].sel), sb[i].exp);
               end
               sb.delete(i);
            end
         end
         @(posedge HCLK);
         #1;
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         case (c)
            0: begin
               drive_m0(IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
               drive_m1(NONSEQ, 32'h2000_0200, 1'b1, SINGLE, 1'b0);
               bus.HWDATA_M0 = 32'h3333_3333;
            end
            1: begin
               push(0, "mid_hmaster_m1", S_HMASTER, 32'd1);
            end
            2: begin
               drive_m1(IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
               bus.HWDATA_M1 = 32'h5A5A_5A5A;
               HRESET = 1'b1;
               push(0, "mid_hwdata_m1", S_HWDATA, 32'h5A5A_5A5A);
               push(1, "mid_rst_hmaster", S_HMASTER, 32'd0);
               push(1, "mid_rst_hwdata", S_HWDATA, 32'h3333_3333);
               push(1, "mid_rst_hready_m1", S_HREADY_M1, 32'd0);
            end
            3: begin
               HRESET = 1'b0;
            end
            default: ;
         endcase
         #2;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
               checks++;
               if (observe(sb[i].sel) !== sb[i].exp) begin
                  errors++;
                  $display("[TB] FAIL %s cyc %0d: got %h expected %h", sb[i].tag, cyc, observe(sb[i].sel), sb[i].exp);
               end
               sb.delete(i);
            end
         end
         @(posedge HCLK);
         #1;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      HRESET = 1'b1;
      idle_all();
      @(posedge HCLK);
      #1;

      test_reset();
      test_handover();
      test_burst();
      test_lock();
      test_starve();
      test_resp();
      test_reset_mid();

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
